msrv32_ahb_data_bridge: RTL and testbench

MSRV32_AHB_DATA_BRIDGE -- requirements
Module: msrv32_ahb_data_bridge

---
 rtl/msrv32_ahb_data_bridge.sv | 128 ++++++++++++
 tb/tb_msrv32_ahb_data_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_ahb_data_bridge.sv
// rtl/msrv32_ahb_data_bridge.sv - single-outstanding core load/store to AHB-Lite master bridge
module msrv32_ahb_data_bridge #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] core_addr_in,
  input  logic [31:0] core_wdata_in,
  input  logic        core_wr_req_in,
  input  logic        core_rd_req_in,
  input  logic [1:0]  core_size_in,
  output logic        core_hready_out,
  output logic        core_done_out,
  output logic        core_hresp_out,
  output logic [31:0] core_rdata_out,
  output logic        timeout_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_ERR   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] wdata_q;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_nxt;
  logic        misaligned;
  logic        accept;
  logic        enter_data;
  logic        done_ok;
  logic        done_err;
  logic        in_data_nxt;

  always_comb begin
    misaligned = 1'b0;
    case (core_size_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = core_addr_in[0];
      2'b10:   misaligned = (core_addr_in[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) state <= S_IDLE;
    else                      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (core_wr_req_in || core_rd_req_in) state_nxt = misaligned ? S_FAULT : S_ADDR;
      S_ADDR:  if (hready_in) state_nxt = S_DATA;
      S_DATA: begin
        if (hready_in)     state_nxt = S_IDLE;
        else if (hresp_in) state_nxt = S_ERR;
      end
      S_ERR:   if (hready_in) state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A ready slave in the error phase (or an error on the same cycle as ready) ends the access as a bus error.
  always_comb begin
    core_hready_out = (state == S_IDLE);
    accept          = core_hready_out && (core_wr_req_in || core_rd_req_in);
    enter_data      = (state == S_ADDR) && hready_in;
    done_ok         = (state == S_DATA) && hready_in && !hresp_in;
    done_err        = ((state == S_DATA) && hready_in && hresp_in) ||
                      ((state == S_ERR) && hready_in) ||
                      (state == S_FAULT);
    in_data_nxt     = (state_nxt == S_DATA) || (state_nxt == S_ERR);
    wait_cnt_nxt    = wait_cnt;
    if (enter_data)
      wait_cnt_nxt = 8'd0;
    else if (((state == S_DATA) || (state == S_ERR)) && !hready_in && (wait_cnt != 8'hFF))
      wait_cnt_nxt = wait_cnt + 8'd1;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      htrans_out     <= 2'b00;
      haddr_out      <= 32'd0;
      hwrite_out     <= 1'b0;
      hsize_out      <= 3'd0;
      hwdata_out     <= 32'd0;
      wdata_q        <= 32'd0;
      core_rdata_out <= 32'd0;
      core_done_out  <= 1'b0;
      core_hresp_out <= 1'b0;
      timeout_out    <= 1'b0;
      wait_cnt       <= 8'd0;
    end else begin
      htrans_out     <= (state_nxt == S_ADDR) ? 2'b10 : 2'b00;
      core_done_out  <= done_ok || done_err;
      core_hresp_out <= done_err;
      wait_cnt       <= wait_cnt_nxt;
      timeout_out    <= in_data_nxt && (wait_cnt_nxt >= LIMIT);
      if (accept) begin
        haddr_out  <= core_addr_in;
        hwrite_out <= core_wr_req_in;
        hsize_out  <= {1'b0, core_size_in};
        wdata_q    <= core_wdata_in;
      end
      if (enter_data)
        hwdata_out <= hwrite_out ? wdata_q : 32'd0;
      if (done_ok && !hwrite_out)
        core_rdata_out <= hrdata_in;
    end
  end

endmodule

// File: tb/tb_msrv32_ahb_data_bridge.sv
// tb/tb_msrv32_ahb_data_bridge.sv - scoreboard bench for msrv32_ahb_data_bridge
module tb_msrv32_ahb_data_bridge;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] core_addr_in = '0;
  logic [31:0] core_wdata_in = '0;
  logic        core_wr_req_in = 1'b0;
  logic        core_rd_req_in = 1'b0;
  logic [1:0]  core_size_in = '0;
  logic        core_hready_out;
  logic        core_done_out;
  logic        core_hresp_out;
  logic [31:0] core_rdata_out;
  logic        timeout_out;
  logic [31:0] haddr_out;
  logic [1:0]  htrans_out;
  logic        hwrite_out;
  logic [2:0]  hsize_out;
  logic [31:0] hwdata_out;
  logic [31:0] hrdata_in = '0;
  logic        hready_in = 1'b1;
  logic        hresp_in = 1'b0;

  msrv32_ahb_data_bridge #(.WAIT_LIMIT(LIMIT)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .core_addr_in(core_addr_in),
    .core_wdata_in(core_wdata_in),
    .core_wr_req_in(core_wr_req_in),
    .core_rd_req_in(core_rd_req_in),
    .core_size_in(core_size_in),
    .core_hready_out(core_hready_out),
    .core_done_out(core_done_out),
    .core_hresp_out(core_hresp_out),
    .core_rdata_out(core_rdata_out),
    .timeout_out(timeout_out),
    .haddr_out(haddr_out),
    .htrans_out(htrans_out),
    .hwrite_out(hwrite_out),
    .hsize_out(hsize_out),
    .hwdata_out(hwdata_out),
    .hrdata_in(hrdata_in),
    .hready_in(hready_in),
    .hresp_in(hresp_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rdata = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && core_done_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_hresp", core_hresp_out, e.resp);
        chk("done_rdata", core_rdata_out, e.rdata);
        chk("done_timeout", timeout_out, 0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input int addr_waits, input int data_waits,
                        input bit err, input logic [31:0] rdata);
    bit   illegal;
    int   n;
    int   waits;
    int   ncyc;
    exp_t e;
    n = 0;
    while (!core_hready_out && n < 50) begin
      next_cycle();
      n++;
    end
    if (n >= 50) chk("idle_wait_timeout", 0, 1);
    illegal = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    e.resp  = illegal || err;
    if (!illegal && !err && !wr) model_rdata = rdata;
    e.rdata = model_rdata;
    exp_q.push_back(e);
    core_wr_req_in = wr;
    core_rd_req_in = !wr || ($urandom_range(0, 1) == 1);
    core_addr_in   = addr;
    core_size_in   = size;
    core_wdata_in  = wdata;
    hready_in      = 1'b1;
    hresp_in       = 1'b0;
    @(negedge clk);
    chk("accept_hready", core_hready_out, 1);
    next_cycle();
    core_wr_req_in = 1'b0;
    core_rd_req_in = 1'b0;
    core_addr_in   = $urandom;
    core_wdata_in  = $urandom;
    core_size_in   = 2'($urandom_range(0, 3));
    if (illegal) begin
      @(negedge clk);
      chk("fault_htrans", htrans_out, 0);
      chk("fault_busy", core_hready_out, 0);
      next_cycle();
      return;
    end
    for (int i = 0; i <= addr_waits; i++) begin
      hready_in = (i == addr_waits);
      @(negedge clk);
      chk("addr_htrans", htrans_out, 2);
      chk("addr_haddr", haddr_out, addr);
      chk("addr_hwrite", hwrite_out, wr);
      chk("addr_hsize", hsize_out, {1'b0, size});
      next_cycle();
    end
    waits = 0;
    ncyc  = data_waits + (err ? 2 : 1);
    for (int i = 0; i < ncyc; i++) begin
      if (i < data_waits) begin
        hready_in = 1'b0; hresp_in = 1'b0;
      end else if (err && i == data_waits) begin
        hready_in = 1'b0; hresp_in = 1'b1;
      end else begin
        hready_in = 1'b1; hresp_in = err;
      end
      hrdata_in = (hready_in && !err) ? rdata : $urandom;
      @(negedge clk);
      chk("data_htrans", htrans_out, 0);
      chk("data_hwdata", hwdata_out, wr ? wdata : 32'd0);
      chk("data_haddr", haddr_out, addr);
      chk("data_timeout", timeout_out, (waits >= LIMIT) ? 1 : 0);
      next_cycle();
      if (!hready_in) waits++;
    end
    hready_in = 1'b1;
    hresp_in  = 1'b0;
    hrdata_in = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    hrdata_in = 32'h1234_5678;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("rst_htrans", htrans_out, 0);
    chk("rst_haddr", haddr_out, 0);
    chk("rst_hwrite", hwrite_out, 0);
    chk("rst_hsize", hsize_out, 0);
    chk("rst_hwdata", hwdata_out, 0);
    chk("rst_rdata", core_rdata_out, 0);
    chk("rst_done", core_done_out, 0);
    chk("rst_hresp", core_hresp_out, 0);
    chk("rst_timeout", timeout_out, 0);
    chk("rst_hready", core_hready_out, 1);
    next_cycle();
    rst = 1'b0;

    do_txn(1'b0, 32'h100, 2'b10, 32'h0, 0, 0, 1'b0, 32'hDEADBEEF);
    do_txn(1'b1, 32'h203, 2'b00, 32'hAA000000, 0, 3, 1'b0, 32'h0);
    do_txn(1'b0, 32'h101, 2'b01, 32'h0, 0, 0, 1'b0, 32'h0);
    do_txn(1'b0, 32'h300, 2'b10, 32'h0, 1, 0, 1'b1, 32'h0);
    do_txn(1'b0, 32'h304, 2'b10, 32'h0, 0, 6, 1'b0, 32'hCAFEF00D);
    do_txn(1'b1, 32'h002, 2'b10, 32'h5555AAAA, 0, 0, 1'b0, 32'h0);
    do_txn(1'b0, 32'h006, 2'b01, 32'h0, 2, 1, 1'b0, 32'h0BADF00D);
    do_txn(1'b0, 32'h008, 2'b11, 32'h0, 0, 0, 1'b0, 32'h0);

    // Reset during the data phase must drop the access silently.
    while (!core_hready_out) next_cycle();
    core_rd_req_in = 1'b1; core_addr_in = 32'h40; core_size_in = 2'b10;
    next_cycle();
    core_rd_req_in = 1'b0;
    hready_in = 1'b1;
    next_cycle();
    hready_in = 1'b0;
    @(negedge clk);
    chk("pre_rst_htrans", htrans_out, 0);
    chk("pre_rst_busy", core_hready_out, 0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    hready_in = 1'b1;
    model_rdata = 32'h0;
    @(negedge clk);
    chk("midrst_htrans", htrans_out, 0);
    chk("midrst_hready", core_hready_out, 1);
    chk("midrst_done", core_done_out, 0);
    chk("midrst_rdata", core_rdata_out, 0);
    next_cycle();
    do_txn(1'b0, 32'h10, 2'b10, 32'h0, 0, 0, 1'b0, 32'h600DC0DE);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [1:0]  s;
      a = $urandom;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b11) s = 2'b10;
        if (s == 2'b10) a[1:0] = 2'b00;
        if (s == 2'b01) a[0] = 1'b0;
      end
      do_txn(1'($urandom_range(0, 1)), a, s, $urandom, $urandom_range(0, 2),
             $urandom_range(0, 7), ($urandom_range(0, 4) == 0), $urandom);
    end

    repeat (3) next_cycle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
